// File: rtl/mac_result_buffer_pkg.sv
// Shared types and constants for the MAC result buffer (package mac_pkg).
package mac_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned DEPTH_DEF  = 8;

  typedef struct packed {
    logic                         ovf;
    logic signed [DATA_W_DEF-1:0] data;
  } mac_result_t;

  // Saturation limits at the default width; other widths derive them the same way.
  localparam logic signed [DATA_W_DEF-1:0] SAT_POS_DEF = {1'b0, {(DATA_W_DEF-1){1'b1}}};
  localparam logic signed [DATA_W_DEF-1:0] SAT_NEG_DEF = {1'b1, {(DATA_W_DEF-1){1'b0}}};

endpackage

// File: rtl/mac_result_buffer_if.sv
// MAC-side capture and consumer-side handshake signals of the result buffer.
interface mac_result_buffer_if
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic [DATA_W-1:0] f;
  logic              overflow;
  logic              valid_in;
  logic [DATA_W-1:0] out_data;
  logic              out_ovf;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output f, overflow, valid_in, out_ready,
    input  out_data, out_ovf, out_valid
  );

  modport slave (
    input  f, overflow, valid_in, out_ready,
    output out_data, out_ovf, out_valid
  );
endinterface

// File: rtl/mac_res_fifo.sv
// Generic synchronous FWFT FIFO of result entries; head holds its last value when empty.
module mac_res_fifo
  import mac_pkg::*;
#(
  parameter type         entry_t = mac_result_t,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  entry_t      wdata,
  input  logic        pop,
  output entry_t      head,
  output logic        not_empty,
  output logic [AW:0] count,
  output logic        full
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  entry_t        last_head;

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers are exactly log2(DEPTH) wide, so the increment wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_head <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_head <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign not_empty = (count != '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign head      = not_empty ? mem[rd_ptr] : last_head;

endmodule

// File: rtl/mac_result_buffer.sv
// MAC result buffer: qualifies the handshake, optionally saturates, tracks drops.
// Build option: define MAC_RESULT_SATURATE_EN to clamp overflowed results.
module mac_result_buffer
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  mac_result_buffer_if.slave     bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   drop_err
);

  typedef struct packed {
    logic                     ovf;
    logic signed [DATA_W-1:0] data;
  } entry_t;

  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mac_result_buffer: DEPTH must be a power of two in 2..64");
  end

  entry_t wr_entry;
  entry_t head;
  logic   not_empty;
  logic   push;
  logic   pop;

`ifdef MAC_RESULT_SATURATE_EN
  localparam logic signed [DATA_W-1:0] SAT_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  // A wrapped result with its sign bit set came from positive overflow, and vice versa.
  always_comb begin
    wr_entry.ovf  = bus.overflow;
    wr_entry.data = bus.f;
    if (bus.overflow) begin
      wr_entry.data = bus.f[DATA_W-1] ? SAT_POS : SAT_NEG;
    end
  end
`else
  always_comb begin
    wr_entry.ovf  = bus.overflow;
    wr_entry.data = bus.f;
  end
`endif

  // A pop frees a slot in the same cycle, so a full buffer still accepts a push.
  assign pop  = not_empty && bus.out_ready;
  assign push = bus.valid_in && (!full || pop);

  mac_res_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .wdata     (wr_entry),
    .pop       (pop),
    .head      (head),
    .not_empty (not_empty),
    .count     (count),
    .full      (full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_err <= 1'b0;
    end else if (bus.valid_in && full && !pop) begin
      drop_err <= 1'b1;
    end
  end

  assign bus.out_data  = head.data;
  assign bus.out_ovf   = head.ovf && not_empty;
  assign bus.out_valid = not_empty;

endmodule

// File: tb/tb_mac_result_buffer.sv
// Directed self-checking bench for mac_result_buffer (DATA_W=16, DEPTH=8).
module tb_mac_result_buffer;
  import mac_pkg::*;

  logic       clk;
  logic       reset;
  logic [3:0] count;
  logic       full;
  logic       drop_err;

  int checks;
  int errors;

  mac_result_buffer_if #(.DATA_W(16)) bus ();

  mac_result_buffer #(
    .DATA_W (16),
    .DEPTH  (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .count    (count),
    .full     (full),
    .drop_err (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      bus.valid_in = 1'b1;
      bus.f        = 16'(first + i);
      step();
    end
    bus.valid_in = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  logic [31:0] exp_a;
  logic [31:0] exp_b;
  logic [31:0] exp_list [8];

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.f         = '0;
    bus.overflow  = 1'b0;
    bus.valid_in  = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;

    check("rst_count",    32'(count),         32'd0);
    check("rst_valid",    32'(bus.out_valid), 32'd0);
    check("rst_full",     32'(full),          32'd0);
    check("rst_drop",     32'(drop_err),      32'd0);
    check("rst_data",     32'(bus.out_data),  32'd0);
    check("rst_ovf",      32'(bus.out_ovf),   32'd0);

    // Two pushes with the consumer stalled
    bus.valid_in = 1'b1; bus.f = 16'd4;  step();
    bus.f = 16'd13; step();
    bus.valid_in = 1'b0;
    check("two_count", 32'(count),         32'd2);
    check("two_valid", 32'(bus.out_valid), 32'd1);
    check("two_data",  32'(bus.out_data),  32'd4);
    bus.out_ready = 1'b1;
    step();
    check("two_data2", 32'(bus.out_data),  32'd13);
    check("two_cnt1",  32'(count),         32'd1);
    step();
    bus.out_ready = 1'b0;
    check("empty_valid", 32'(bus.out_valid), 32'd0);
    check("empty_hold",  32'(bus.out_data),  32'd13);
    check("empty_ovf",   32'(bus.out_ovf),   32'd0);

    // Fill, overflow by one, drain
    push_seq(1, 8);
    check("fill_full",  32'(full),     32'd1);
    check("fill_count", 32'(count),    32'd8);
    check("fill_drop",  32'(drop_err), 32'd0);
    push_seq(9, 1);
    check("drop_full",  32'(full),     32'd1);
    check("drop_count", 32'(count),    32'd8);
    check("drop_flag",  32'(drop_err), 32'd1);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain_%0d", i), 32'(bus.out_data), 32'(i));
      step();
    end
    bus.out_ready = 1'b0;
    check("drain_valid", 32'(bus.out_valid), 32'd0);
    check("drain_count", 32'(count),         32'd0);
    check("drop_sticky", 32'(drop_err),      32'd1);
    step();
    check("ready_idle_count", 32'(count), 32'd0);

    // Push and pop together while full
    do_reset();
    check("post_rst_drop", 32'(drop_err), 32'd0);
    push_seq(11, 8);
    bus.valid_in = 1'b1; bus.f = 16'd100; bus.out_ready = 1'b1;
    step();
    bus.valid_in = 1'b0;
    check("pp_count", 32'(count),    32'd8);
    check("pp_drop",  32'(drop_err), 32'd0);
    for (int i = 0; i < 7; i++) exp_list[i] = 32'(12 + i);
    exp_list[7] = 32'd100;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("pp_drain_%0d", i), 32'(bus.out_data), exp_list[i]);
      step();
    end
    check("pp_empty", 32'(bus.out_valid), 32'd0);

    // Push into empty with the consumer ready: no bypass
    bus.valid_in = 1'b1; bus.f = 16'd7; bus.out_ready = 1'b1;
    #1;
    check("lat_valid0", 32'(bus.out_valid), 32'd0);
    step();
    bus.valid_in = 1'b0;
    check("lat_valid1", 32'(bus.out_valid), 32'd1);
    check("lat_data",   32'(bus.out_data),  32'd7);
    step();
    bus.out_ready = 1'b0;
    check("lat_count", 32'(count),        32'd0);
    check("lat_hold",  32'(bus.out_data), 32'd7);

    // Overflowed results
`ifdef MAC_RESULT_SATURATE_EN
    exp_a = 32'h7FFF;
    exp_b = 32'h8000;
`else
    exp_a = 32'h8008;
    exp_b = 32'd32000;
`endif
    bus.valid_in = 1'b1; bus.overflow = 1'b1; bus.f = 16'h8008; step();
    bus.f = 16'd32000; step();
    bus.valid_in = 1'b0; bus.overflow = 1'b0;
    check("sat_data_a", 32'(bus.out_data), exp_a);
    check("sat_ovf_a",  32'(bus.out_ovf),  32'd1);
    bus.out_ready = 1'b1;
    step();
    check("sat_data_b", 32'(bus.out_data), exp_b);
    check("sat_ovf_b",  32'(bus.out_ovf),  32'd1);
    step();
    bus.out_ready = 1'b0;
    check("sat_empty_ovf", 32'(bus.out_ovf), 32'd0);

    // Reset with entries in flight and a push pending
    push_seq(31, 8);
    push_seq(39, 1);
    bus.out_ready = 1'b1;
    step(); step(); step();
    bus.out_ready = 1'b0;
    check("pre_rst_count", 32'(count),    32'd5);
    check("pre_rst_drop",  32'(drop_err), 32'd1);
    check("pre_rst_data",  32'(bus.out_data), 32'd34);
    reset = 1'b1; bus.valid_in = 1'b1; bus.f = 16'd99;
    step();
    reset = 1'b0; bus.valid_in = 1'b0;
    check("mid_rst_count", 32'(count),         32'd0);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_drop",  32'(drop_err),      32'd0);
    check("mid_rst_full",  32'(full),          32'd0);
    check("mid_rst_data",  32'(bus.out_data),  32'd0);
    step();
    check("after_rst_count", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
